wb_reg_writer: RTL and testbench
================================

Name: wb_reg_writer

Overview:
- Writeback-stage sequencer that consumes the MEM/WB pipeline register outputs and turns them into writes on the register file's single write port.
- Dual-destination writes (both wen bits set) and call link writes take two cycles. For those, the block raises a registered stall back to all pipeline registers for the second cycle.
- Also publishes the current write for forwarding and counts retired instructions.

Parameters:
- ADDR_W, 5, register file address width (32 x 8-bit registers)
- OPCODE_CALL, 6'h2C, value of instruction[31:26] that identifies a call
- LINK_LO_ADDR, 5'd30, link register receiving ret_addr[7:0]
- LINK_HI_ADDR, 5'd31, link register receiving {2'b00, ret_addr[13:8]}
- ZERO_REG_RO, 1, when 1, writes to address 0 are suppressed (no wr_en)

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- data_top_in  in  8  top result byte from MEM/WB
- data_bot_in  in  8  bottom result byte from MEM/WB
- instruction_in  in  32  instruction word; [31:26] opcode, [25:21] rd_top, [20:16] rd_bot
- reg_file_wen_in  in  2  bit0 = write top, bit1 = write bottom
- ret_addr_in  in  14  call return address
- wr_en  out  1  register file write enable
- wr_addr  out  ADDR_W  register file write address
- wr_data  out  8  register file write data
- stall_out  out  1  registered stall to the hazard unit / all pipeline registers
- fwd_valid  out  1  equals wr_en, forwarding qualifier
- fwd_addr  out  ADDR_W  equals wr_addr
- fwd_data  out  8  equals wr_data
- retired_count  out  32  count of retired non-bubble instructions

Behaviour:
- Reset (synchronous, active-high): state = IDLE, pending cleared, stall_out = 0, retired_count = 0. wr_en and fwd_valid are 0 during any cycle in which reset is high. A reset asserted in SECOND discards the pending write.
- Write port outputs are combinational from current inputs/state. stall_out is a flop output equal to (state == SECOND).
- States:
  - IDLE: process the incoming instruction. Single write -> stay IDLE. Two writes -> perform the first now, latch the second {addr, data} into pending, go to SECOND.
  - SECOND: drive the pending write and ignore all inputs. MEM/WB outputs are zero here because stall is high. Return to IDLE.
- Timing of a dual write:
  - Cycle N: first write issued.
  - Cycle N+1: second write issued with stall_out = 1. MEM/WB holds the following instruction.
  - Cycle N+2: following instruction visible.
  - Throughput: 2 cycles per dual write, 1 cycle otherwise.
- Decode in IDLE, with call taking priority:
  - opcode == OPCODE_CALL: first write LINK_LO_ADDR <= ret_addr_in[7:0]; second write LINK_HI_ADDR <= {2'b00, ret_addr_in[13:8]}. reg_file_wen_in is ignored.
  - wen = 2'b01: write rd_top <= data_top_in.
  - wen = 2'b10: write rd_bot <= data_bot_in.
  - wen = 2'b11 with rd_top != rd_bot: top first, then bottom (pending).
  - wen = 2'b11 with rd_top == rd_bot: collapse to a single write of data_bot_in, no SECOND, no stall.
  - wen = 2'b00: no write.
- If ZERO_REG_RO = 1 and the write address is 0: wr_en is forced low for that write. Sequencing and stall are unchanged, so dual timing is deterministic.
- Bubble: instruction_in == 0 with wen == 0 -> no write, not counted.
- retired_count:
  - Increments by 1 on the edge ending the final cycle of each non-bubble instruction: the IDLE cycle for single writes or no-write instructions, the SECOND cycle for dual writes.
  - Wraps 32'hFFFFFFFF -> 0.
- Upstream stall from the hazard unit zeroes the MEM/WB outputs, which this block sees as a bubble. No special handling.

Test Plan:
- Reset then instruction_in = 32'h0420_0000 (rd_top = 1), wen = 01, data_top = 8'hA5 -> same cycle wr_en = 1, wr_addr = 1, wr_data = A5; stall_out stays 0; retired_count = 1 after the edge.
- wen = 11, rd_top = 3, rd_bot = 4, data 8'h11/8'h22 -> cycle N writes 3 <= 11; cycle N+1 writes 4 <= 22 with stall_out = 1 and zero inputs; cycle N+2 stall_out = 0; count +1 only once.
- Call opcode 6'h2C, ret_addr = 14'h2A5C, wen = 00 -> r30 <= 8'h5C, then r31 <= 8'h2A with stall_out = 1 in the second cycle.
- wen = 11, rd_top = rd_bot = 7, data 8'h11/8'h22 -> single write 7 <= 22, no stall.
- wen = 01 with rd_top = 0 and ZERO_REG_RO = 1 -> wr_en = 0, retired_count increments. Separately, a bubble (all-zero inputs) -> no write, no count.
- Reset asserted during SECOND -> wr_en = 0 that cycle; next cycle stall_out = 0, state IDLE, retired_count = 0, pending write never issued.

Source files
------------

// File: rtl/wb_reg_writer.sv
// wb_reg_writer
//   Writeback-stage sequencer. Turns MEM/WB outputs into writes on the
//   register file's single write port. Dual-destination writes and call
//   link writes take two cycles, with a registered stall raised during the
//   second cycle. Also publishes the current write for forwarding and counts
//   retired (non-bubble) instructions.
//
// Ports
//   clock, reset         : rising-edge clock, synchronous active-high reset
//   data_top_in          : top result byte from MEM/WB
//   data_bot_in          : bottom result byte from MEM/WB
//   instruction_in       : [31:26] opcode, [25:21] rd_top, [20:16] rd_bot
//   reg_file_wen_in      : bit0 = write top, bit1 = write bottom
//   ret_addr_in          : call return address
//   wr_en/addr/data      : register file write port (combinational)
//   stall_out            : registered stall, high while in the second cycle
//   fwd_valid/addr/data  : copy of the write port for forwarding
//   retired_count        : retired non-bubble instruction count (wraps)
module wb_reg_writer #(
   parameter int unsigned           ADDR_W       = 5,
   parameter logic [5:0]            OPCODE_CALL  = 6'h2C,
   parameter logic [ADDR_W-1:0]     LINK_LO_ADDR = 5'd30,
   parameter logic [ADDR_W-1:0]     LINK_HI_ADDR = 5'd31,
   parameter bit                    ZERO_REG_RO  = 1'b1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [7:0]        data_top_in,
   input  logic [7:0]        data_bot_in,
   input  logic [31:0]       instruction_in,
   input  logic [1:0]        reg_file_wen_in,
   input  logic [13:0]       ret_addr_in,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              stall_out,
   output logic              fwd_valid,
   output logic [ADDR_W-1:0] fwd_addr,
   output logic [7:0]        fwd_data,
   output logic [31:0]       retired_count
);

   typedef enum logic {IDLE, SECOND} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
   logic [7:0]          pend_data_q, pend_data_d;
   logic                stall_q, stall_d;
   logic [31:0]         retired_q, retired_d;

   logic [5:0]          opcode;
   logic [ADDR_W-1:0]   rd_top, rd_bot;
   logic                is_call, is_bubble;
   logic                want_wr, dual, retire;
   logic [ADDR_W-1:0]   sel_addr;
   logic [7:0]          sel_data;

   assign opcode    = instruction_in[31:26];
   assign rd_top    = ADDR_W'(instruction_in[25:21]);
   assign rd_bot    = ADDR_W'(instruction_in[20:16]);
   assign is_call   = (opcode == OPCODE_CALL);
   assign is_bubble = (instruction_in == '0) && (reg_file_wen_in == 2'b00);

   // State / pending / stall / counter registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         pend_addr_q <= '0;
         pend_data_q <= '0;
         stall_q     <= 1'b0;
         retired_q   <= '0;
      end else begin
         state_q     <= state_d;
         pend_addr_q <= pend_addr_d;
         pend_data_q <= pend_data_d;
         stall_q     <= stall_d;
         retired_q   <= retired_d;
      end
   end

   // Decode: selects the write for this cycle and whether a second one follows
   always_comb begin
      want_wr     = 1'b0;
      dual        = 1'b0;
      sel_addr    = '0;
      sel_data    = '0;
      pend_addr_d = pend_addr_q;
      pend_data_d = pend_data_q;
      if (state_q == SECOND) begin
         want_wr  = 1'b1;
         sel_addr = pend_addr_q;
         sel_data = pend_data_q;
      end else if (is_call) begin
         want_wr     = 1'b1;
         dual        = 1'b1;
         sel_addr    = LINK_LO_ADDR;
         sel_data    = ret_addr_in[7:0];
         pend_addr_d = LINK_HI_ADDR;
         pend_data_d = {2'b00, ret_addr_in[13:8]};
      end else begin
         unique case (reg_file_wen_in)
            2'b01: begin
               want_wr  = 1'b1;
               sel_addr = rd_top;
               sel_data = data_top_in;
            end
            2'b10: begin
               want_wr  = 1'b1;
               sel_addr = rd_bot;
               sel_data = data_bot_in;
            end
            2'b11: begin
               want_wr = 1'b1;
               if (rd_top == rd_bot) begin
                  // Same destination: bottom wins, single cycle
                  sel_addr = rd_bot;
                  sel_data = data_bot_in;
               end else begin
                  dual        = 1'b1;
                  sel_addr    = rd_top;
                  sel_data    = data_top_in;
                  pend_addr_d = rd_bot;
                  pend_data_d = data_bot_in;
               end
            end
            default: ;
         endcase
      end
   end

   // Next-state
   always_comb begin
      state_d = IDLE;
      if (state_q == IDLE && dual) state_d = SECOND;
   end

   // Outputs / counter next value
   always_comb begin
      // Address-0 suppression only masks the enable; sequencing is unchanged
      wr_en     = want_wr && !reset && !(ZERO_REG_RO && (sel_addr == '0));
      wr_addr   = sel_addr;
      wr_data   = sel_data;
      fwd_valid = wr_en;
      fwd_addr  = sel_addr;
      fwd_data  = sel_data;
      stall_d   = (state_d == SECOND);
      retire    = (state_q == SECOND) || (!dual && !is_bubble);
      retired_d = retire ? retired_q + 32'd1 : retired_q;
   end

   assign stall_out     = stall_q;
   assign retired_count = retired_q;

endmodule

// File: tb/tb_wb_reg_writer.sv
module tb_wb_reg_writer;

   logic        clock = 1'b0;
   logic        reset;
   logic [7:0]  data_top_in, data_bot_in;
   logic [31:0] instruction_in;
   logic [1:0]  reg_file_wen_in;
   logic [13:0] ret_addr_in;
   logic        wr_en, stall_out, fwd_valid;
   logic [4:0]  wr_addr, fwd_addr;
   logic [7:0]  wr_data, fwd_data;
   logic [31:0] retired_count;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   wb_reg_writer #(
      .ADDR_W       (5),
      .OPCODE_CALL  (6'h2C),
      .LINK_LO_ADDR (5'd30),
      .LINK_HI_ADDR (5'd31),
      .ZERO_REG_RO  (1'b1)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .data_top_in     (data_top_in),
      .data_bot_in     (data_bot_in),
      .instruction_in  (instruction_in),
      .reg_file_wen_in (reg_file_wen_in),
      .ret_addr_in     (ret_addr_in),
      .wr_en           (wr_en),
      .wr_addr         (wr_addr),
      .wr_data         (wr_data),
      .stall_out       (stall_out),
      .fwd_valid       (fwd_valid),
      .fwd_addr        (fwd_addr),
      .fwd_data        (fwd_data),
      .retired_count   (retired_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Apply inputs just after the falling edge, settle, then checks follow
   task automatic drive(input logic [31:0] ins, input logic [1:0] wen,
                        input logic [7:0] top, input logic [7:0] bot,
                        input logic [13:0] ret);
      @(negedge clock);
      instruction_in  = ins;
      reg_file_wen_in = wen;
      data_top_in     = top;
      data_bot_in     = bot;
      ret_addr_in     = ret;
      #1;
   endtask

   task automatic edge_wait();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_wr(input string tag, input logic en, input logic [4:0] a,
                         input logic [7:0] d);
      chk({tag, "_en"}, 32'(wr_en), 32'(en));
      chk({tag, "_fv"}, 32'(fwd_valid), 32'(en));
      if (en) begin
         chk({tag, "_addr"}, 32'(wr_addr), 32'(a));
         chk({tag, "_data"}, 32'(wr_data), 32'(d));
         chk({tag, "_faddr"}, 32'(fwd_addr), 32'(a));
         chk({tag, "_fdata"}, 32'(fwd_data), 32'(d));
      end
   endtask

   initial begin
      reset = 1'b1;
      instruction_in = '0; reg_file_wen_in = '0;
      data_top_in = '0; data_bot_in = '0; ret_addr_in = '0;

      // Write request during reset must be masked
      drive(32'h0420_0000, 2'b01, 8'hA5, 8'h00, 14'h0);
      chk_wr("rst_mask", 1'b0, 5'd0, 8'h00);
      edge_wait();
      chk("rst_stall", 32'(stall_out), 32'd0);
      chk("rst_cnt", retired_count, 32'd0);

      // Single top write
      reset = 1'b0;
      drive(32'h0420_0000, 2'b01, 8'hA5, 8'h00, 14'h0);
      chk_wr("single_top", 1'b1, 5'd1, 8'hA5);
      chk("single_top_stall", 32'(stall_out), 32'd0);
      edge_wait();
      chk("single_top_cnt", retired_count, 32'd1);
      chk("single_top_stall2", 32'(stall_out), 32'd0);

      // Dual write r3 <= 11, r4 <= 22
      drive(32'h0064_0000, 2'b11, 8'h11, 8'h22, 14'h0);
      chk_wr("dual_n", 1'b1, 5'd3, 8'h11);
      edge_wait();
      chk("dual_n_stall", 32'(stall_out), 32'd1);
      chk("dual_n_cnt", retired_count, 32'd1);
      drive(32'h0, 2'b00, 8'h00, 8'h00, 14'h0);
      chk_wr("dual_n1", 1'b1, 5'd4, 8'h22);
      chk("dual_n1_stall", 32'(stall_out), 32'd1);
      edge_wait();
      chk("dual_n2_stall", 32'(stall_out), 32'd0);
      chk("dual_n2_cnt", retired_count, 32'd2);

      // Bubble after dual: nothing written, not counted
      drive(32'h0, 2'b00, 8'h00, 8'h00, 14'h0);
      chk_wr("bubble_a", 1'b0, 5'd0, 8'h00);
      edge_wait();
      chk("bubble_a_cnt", retired_count, 32'd2);

      // Call: r30 <= 5C, r31 <= 2A
      drive(32'hB000_0000, 2'b00, 8'hFF, 8'hEE, 14'h2A5C);
      chk_wr("call_lo", 1'b1, 5'd30, 8'h5C);
      edge_wait();
      chk("call_stall", 32'(stall_out), 32'd1);
      drive(32'h0, 2'b00, 8'h00, 8'h00, 14'h0);
      chk_wr("call_hi", 1'b1, 5'd31, 8'h2A);
      edge_wait();
      chk("call_stall_end", 32'(stall_out), 32'd0);
      chk("call_cnt", retired_count, 32'd3);

      // Same destination collapses to one write of bottom data
      drive(32'h00E7_0000, 2'b11, 8'h11, 8'h22, 14'h0);
      chk_wr("collapse", 1'b1, 5'd7, 8'h22);
      edge_wait();
      chk("collapse_stall", 32'(stall_out), 32'd0);
      chk("collapse_cnt", retired_count, 32'd4);

      // Write to r0 suppressed, still retires
      drive(32'h0000_0001, 2'b01, 8'h55, 8'h00, 14'h0);
      chk_wr("zero_reg", 1'b0, 5'd0, 8'h00);
      chk("zero_reg_addr", 32'(wr_addr), 32'd0);
      edge_wait();
      chk("zero_reg_cnt", retired_count, 32'd5);

      // Bottom-only write r9 <= 77
      drive(32'h0009_0000, 2'b10, 8'h00, 8'h77, 14'h0);
      chk_wr("single_bot", 1'b1, 5'd9, 8'h77);
      edge_wait();
      chk("single_bot_cnt", retired_count, 32'd6);

      // Bubble
      drive(32'h0, 2'b00, 8'h00, 8'h00, 14'h0);
      chk_wr("bubble_b", 1'b0, 5'd0, 8'h00);
      edge_wait();
      chk("bubble_b_cnt", retired_count, 32'd6);

      // Reset during SECOND discards the pending write
      drive(32'h00A6_0000, 2'b11, 8'h33, 8'h44, 14'h0);
      chk_wr("rs_first", 1'b1, 5'd5, 8'h33);
      edge_wait();
      chk("rs_stall", 32'(stall_out), 32'd1);
      @(negedge clock);
      reset = 1'b1;
      instruction_in = '0; reg_file_wen_in = '0;
      data_top_in = '0; data_bot_in = '0; ret_addr_in = '0;
      #1;
      chk_wr("rs_mask", 1'b0, 5'd0, 8'h00);
      edge_wait();
      chk("rs_stall_clr", 32'(stall_out), 32'd0);
      chk("rs_cnt_clr", retired_count, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk_wr("rs_no_pending", 1'b0, 5'd0, 8'h00);
      edge_wait();
      chk("rs_idle_stall", 32'(stall_out), 32'd0);
      chk("rs_idle_cnt", retired_count, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
